reg_bank_ctx: RTL and testbench

REG_BANK_CTX -- requirements
Module: reg_bank_ctx

---
 rtl/reg_bank_ctx_if.sv | 33 +++
 rtl/reg_bank_ctx.sv | 128 ++++++++++++
 tb/tb_reg_bank_ctx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_ctx_if.sv
// Register bank bus: three read ports, general/aux/link write ports,
// context save/restore requests and status.
interface reg_bank_ctx_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1, rd_addr2, rd_addr3;
  logic              rd_ind;
  logic              wr_en, wr_ind;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              aux_we, link_we;
  logic [DATA_W-1:0] aux_data, link_data;
  logic              ctx_save, ctx_restore;
  logic [DATA_W-1:0] rd_data1, rd_data2, rd_data3;
  logic              ctx_busy, ctx_done, wr_drop;

  modport master (
    output rd_addr1, rd_addr2, rd_addr3, rd_ind,
    output wr_en, wr_ind, wr_addr, wr_data,
    output aux_we, aux_data, link_we, link_data,
    output ctx_save, ctx_restore,
    input  rd_data1, rd_data2, rd_data3, ctx_busy, ctx_done, wr_drop
  );

  modport slave (
    input  rd_addr1, rd_addr2, rd_addr3, rd_ind,
    input  wr_en, wr_ind, wr_addr, wr_data,
    input  aux_we, aux_data, link_we, link_data,
    input  ctx_save, ctx_restore,
    output rd_data1, rd_data2, rd_data3, ctx_busy, ctx_done, wr_drop
  );
endinterface

// File: rtl/reg_bank_ctx.sv
// Register bank with registered reads, indirect access through a pointer
// register, prioritised side-write ports and a shadow bank that is
// saved/restored one register per cycle.
// Optional: define REG_BANK_CTX_BYPASS_EN to forward same-cycle write data
// to reads of the written register.
module reg_bank_ctx #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PTR_REG  = 18,
  parameter int AUX_REG  = 30,
  parameter int LINK_REG = 31,
  parameter int ZERO_R0  = 1
) (
  input  logic           nativeCLK,
  input  logic           Reset,
  reg_bank_ctx_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d, drop_q, drop_d;
  logic [DATA_W-1:0] regs_q   [DEPTH];
  logic [DATA_W-1:0] regs_d   [DEPTH];
  logic [DATA_W-1:0] shadow_q [DEPTH];
  logic [DATA_W-1:0] rv       [3];
  logic [ADDR_W-1:0] ra       [3];
  logic              busy, last;
  logic              gen_acc, aux_acc, link_acc;
  logic [ADDR_W-1:0] ptr, gwa;

  assign busy     = (state_q != IDLE);
  assign last     = (cnt_q == ADDR_W'(DEPTH-1));
  // Port writes are only accepted while no context copy is running.
  assign gen_acc  = bus.wr_en   & ~busy;
  assign aux_acc  = bus.aux_we  & ~busy;
  assign link_acc = bus.link_we & ~busy;
  // Pointer is taken from pre-write contents, so a write to the pointer
  // register only redirects accesses from the next cycle on.
  assign ptr      = regs_q[PTR_REG][ADDR_W-1:0];
  assign gwa      = bus.wr_ind ? ptr : bus.wr_addr;
  assign ra[0]    = bus.rd_addr1;
  assign ra[1]    = bus.rd_addr2;
  assign ra[2]    = bus.rd_ind ? ptr : bus.rd_addr3;

  assign bus.ctx_busy = busy;
  assign bus.ctx_done = done_q;
  assign bus.wr_drop  = drop_q;

  // Next state and copy counter for the save/restore sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    drop_d  = busy & (bus.wr_en | bus.aux_we | bus.link_we);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.ctx_save)         state_d = SAVE;
        else if (bus.ctx_restore) state_d = RESTORE;
      end
      SAVE, RESTORE: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next bank contents; later assignments win (link > aux > general).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (state_q == RESTORE && cnt_q == ADDR_W'(i)) regs_d[i] = shadow_q[i];
      if (gen_acc  && gwa == ADDR_W'(i))             regs_d[i] = bus.wr_data;
      if (aux_acc  && i == AUX_REG)                  regs_d[i] = bus.aux_data;
      if (link_acc && i == LINK_REG)                 regs_d[i] = bus.link_data;
      if (ZERO_R0 != 0 && i == 0)                    regs_d[i] = '0;
    end
  end

  // Read mux, optionally forwarding data accepted in the same cycle.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rv[p] = regs_q[ra[p]];
`ifdef REG_BANK_CTX_BYPASS_EN
      if ((gen_acc  && gwa == ra[p]) ||
          (aux_acc  && ra[p] == ADDR_W'(AUX_REG)) ||
          (link_acc && ra[p] == ADDR_W'(LINK_REG)))
        rv[p] = regs_d[ra[p]];
`endif
    end
  end

  // Main bank, sequencer and registered outputs; reset wins over everything.
  always_ff @(posedge nativeCLK) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
      bus.rd_data1 <= '0;
      bus.rd_data2 <= '0;
      bus.rd_data3 <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
      bus.rd_data1 <= rv[0];
      bus.rd_data2 <= rv[1];
      bus.rd_data3 <= rv[2];
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Shadow bank is never cleared; a reset mid-save keeps the partial copy.
  always_ff @(posedge nativeCLK) begin
    if (!Reset && state_q == SAVE) shadow_q[cnt_q] <= regs_q[cnt_q];
  end
endmodule

// File: tb/tb_reg_bank_ctx.sv
// Scoreboard bench for reg_bank_ctx: expected read data is queued when the
// read address is driven and compared after the following clock edge.
module tb_reg_bank_ctx;
  logic nativeCLK = 1'b0;
  logic Reset;
  always #5 nativeCLK = ~nativeCLK;

  reg_bank_ctx_if #(.DATA_W(32), .ADDR_W(5)) bus();
  reg_bank_ctx dut (.nativeCLK(nativeCLK), .Reset(Reset), .bus(bus));

  int n_chk = 0, n_pass = 0;
  int busy_cyc = 0, done_cyc = 0;
  logic [31:0] mdl [32];
  logic [31:0] shd [32];
  string       q_tag  [$];
  int          q_port [$];
  logic [31:0] q_exp  [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push(input string tag, input int port, input logic [31:0] exp);
    q_tag.push_back(tag);
    q_port.push_back(port);
    q_exp.push_back(exp);
  endtask

  // Advance one cycle, sample after the edge, retire all due expectations.
  task automatic tick();
    string tg; int pt; logic [31:0] ex, got;
    @(posedge nativeCLK);
    #1;
    if (bus.ctx_busy) busy_cyc++;
    if (bus.ctx_done) done_cyc++;
    while (q_exp.size() > 0) begin
      tg = q_tag.pop_front();
      pt = q_port.pop_front();
      ex = q_exp.pop_front();
      got = (pt == 1) ? bus.rd_data1 : (pt == 2) ? bus.rd_data2 : bus.rd_data3;
      chk(tg, got, ex);
    end
  endtask

  task automatic idle_in();
    bus.rd_addr1 = '0; bus.rd_addr2 = '0; bus.rd_addr3 = '0; bus.rd_ind = 1'b0;
    bus.wr_en = 1'b0; bus.wr_ind = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.aux_we = 1'b0; bus.aux_data = '0; bus.link_we = 1'b0; bus.link_data = '0;
    bus.ctx_save = 1'b0; bus.ctx_restore = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = 5'(a); bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    if (a != 0) mdl[a] = d;
  endtask

  task automatic rd_chk(input int a1, input int a2, input int a3, input logic ind, input string tag);
    int p3;
    bus.rd_addr1 = 5'(a1); bus.rd_addr2 = 5'(a2); bus.rd_addr3 = 5'(a3); bus.rd_ind = ind;
    p3 = ind ? int'(mdl[18][4:0]) : a3;
    push($sformatf("%s_r%0d", tag, a1), 1, mdl[a1]);
    push($sformatf("%s_r%0d", tag, a2), 2, mdl[a2]);
    push($sformatf("%s_r%0d", tag, p3), 3, mdl[p3]);
    tick();
    bus.rd_ind = 1'b0;
  endtask

  task automatic rd_all(input string tag);
    for (int i = 0; i < 32; i += 3) rd_chk(i, (i + 1) % 32, (i + 2) % 32, 1'b0, tag);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && bus.ctx_busy; i++) tick();
    chk({tag, "_timeout"}, 32'(bus.ctx_busy), 32'd0);
    tick();
  endtask

  initial begin
    idle_in();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    chk("rst_rd1", bus.rd_data1, 32'd0);
    chk("rst_rd3", bus.rd_data3, 32'd0);
    chk("rst_busy", 32'(bus.ctx_busy), 32'd0);
    chk("rst_done", 32'(bus.ctx_done), 32'd0);
    chk("rst_drop", 32'(bus.wr_drop), 32'd0);

    // Basic write/read and r0 hardwired to zero.
    wr(5, 32'hDEADBEEF);
    rd_chk(5, 0, 5, 1'b0, "basic");
    wr(0, 32'h1);
    rd_chk(0, 5, 0, 1'b0, "r0");

    // Indirect write and read through the pointer register.
    wr(18, 32'd7);
    bus.wr_en = 1'b1; bus.wr_ind = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h55;
    tick();
    bus.wr_en = 1'b0; bus.wr_ind = 1'b0;
    mdl[7] = 32'h55;
    rd_chk(7, 3, 9, 1'b1, "ind");

    // Same-cycle writes: link beats general on r31, aux to r30 also lands.
    wr(31, 32'h77);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = 32'h1;
    bus.link_we = 1'b1; bus.link_data = 32'h2;
    bus.aux_we = 1'b1; bus.aux_data = 32'hA;
    bus.rd_addr1 = 5'd31;
`ifdef REG_BANK_CTX_BYPASS_EN
    push("prio_same_cycle", 1, 32'h2);
`else
    push("prio_same_cycle", 1, 32'h77);
`endif
    tick();
    idle_in();
    mdl[31] = 32'h2; mdl[30] = 32'hA;
    rd_chk(31, 30, 5, 1'b0, "prio");
    bus.wr_en = 1'b1; bus.wr_addr = 5'd30; bus.wr_data = 32'hB;
    bus.aux_we = 1'b1; bus.aux_data = 32'hC;
    tick();
    idle_in();
    mdl[30] = 32'hC;
    rd_chk(30, 31, 30, 1'b0, "aux_gen");

    // Fill, save (restore asserted alongside is ignored), drop writes while busy.
    for (int i = 1; i < 32; i++) wr(i, 32'(i));
    busy_cyc = 0; done_cyc = 0;
    bus.ctx_save = 1'b1; bus.ctx_restore = 1'b1;
    tick();
    bus.ctx_save = 1'b0; bus.ctx_restore = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'hFFFF;
    bus.ctx_restore = 1'b1;
    tick();
    idle_in();
    chk("drop_pulse", 32'(bus.wr_drop), 32'd1);
    rd_chk(4, 1, 2, 1'b0, "busy_rd");
    chk("drop_clear", 32'(bus.wr_drop), 32'd0);
    wait_idle("save");
    chk("save_busy_cycles", 32'(busy_cyc), 32'd32);
    chk("save_done_pulses", 32'(done_cyc), 32'd1);
    for (int i = 0; i < 32; i++) shd[i] = mdl[i];

    // Overwrite, then restore and read everything back.
    for (int i = 1; i < 32; i++) wr(i, 32'h100 + 32'(i));
    rd_chk(1, 17, 31, 1'b0, "ovw");
    busy_cyc = 0; done_cyc = 0;
    bus.ctx_restore = 1'b1;
    tick();
    bus.ctx_restore = 1'b0;
    wait_idle("restore");
    chk("rest_busy_cycles", 32'(busy_cyc), 32'd32);
    chk("rest_done_pulses", 32'(done_cyc), 32'd1);
    for (int i = 0; i < 32; i++) mdl[i] = shd[i];
    rd_all("restored");

    // Reset while saving at copy index 10: shadow keeps indices 0..9 only.
    for (int i = 1; i < 32; i++) wr(i, 32'h200 + 32'(i));
    bus.ctx_save = 1'b1;
    tick();
    bus.ctx_save = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    Reset = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h999;
    tick();
    idle_in();
    Reset = 1'b0;
    chk("abort_busy", 32'(bus.ctx_busy), 32'd0);
    chk("abort_done", 32'(bus.ctx_done), 32'd0);
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    rd_all("cleared");
    for (int i = 1; i < 10; i++) shd[i] = 32'h200 + 32'(i);
    bus.ctx_restore = 1'b1;
    tick();
    bus.ctx_restore = 1'b0;
    wait_idle("partial");
    for (int i = 0; i < 32; i++) mdl[i] = shd[i];
    rd_all("partial");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
